// File: rtl/i2s_transceiver.sv
// i2s_transceiver: I2S master generating mclk/bclk/lrclk, receiving the left
// channel from the ADC and transmitting one sample on both DAC channels.
module i2s_transceiver #(
  parameter int data_width = 16,
  parameter int bclk_half  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [data_width-1:0] out_sample,
  output logic signed [data_width-1:0] in_sample,
  output logic                         in_valid,
  output logic                         mclk,
  output logic                         bclk,
  output logic                         lrclk,
  input  logic                         i2s_din,
  output logic                         i2s_dout
);
  localparam int W  = data_width;
  localparam int FW = $clog2(2 * W);
  localparam int DW = $clog2(bclk_half);
  logic [DW-1:0] div;
  logic [FW-1:0] f, nf;
  logic [W-1:0] tx_shift, tx_hold, rx_shift;
  logic wrap, rise, fall;
  assign wrap = div == DW'(bclk_half - 1);
  assign rise = wrap & ~bclk;
  assign fall = wrap & bclk;
  assign nf   = f == FW'(2 * W - 1) ? '0 : f + 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {mclk, bclk, lrclk, i2s_dout, in_valid} <= '0;
      div       <= '0;
      f         <= FW'(2 * W - 1);
      tx_shift  <= '0;
      tx_hold   <= '0;
      rx_shift  <= '0;
      in_sample <= '0;
    end else if (!enable) begin
      {mclk, bclk, lrclk, i2s_dout, in_valid} <= '0;
      div      <= '0;
      f        <= FW'(2 * W - 1);
      tx_shift <= '0;
      tx_hold  <= '0;
      rx_shift <= '0;
    end else begin
      mclk     <= ~mclk;
      div      <= wrap ? '0 : div + 1'b1;
      in_valid <= rise && f == FW'(W - 1);
      if (wrap) bclk <= ~bclk;
      if (fall) begin
        f     <= nf;
        lrclk <= nf >= FW'(W - 1) && nf <= FW'(2 * W - 2);
        // the sample is latched once per frame and replayed for the right slot
        if (nf == '0) begin
          tx_shift <= out_sample;
          tx_hold  <= out_sample;
          i2s_dout <= out_sample[W-1];
        end else if (nf == FW'(W)) begin
          tx_shift <= tx_hold;
          i2s_dout <= tx_hold[W-1];
        end else begin
          tx_shift <= {tx_shift[W-2:0], 1'b0};
          i2s_dout <= tx_shift[W-2];
        end
      end
      if (rise) begin
        rx_shift <= {rx_shift[W-2:0], i2s_din};
        if (f == FW'(W - 1)) in_sample <= {rx_shift[W-2:0], i2s_din};
      end
    end
endmodule
